// File: rtl/alpha_llr_mem_pkg.sv
// Shared constants and layout helpers for the per-layer alpha (LLR) store.
// Layer L occupies max(1, 2^L/P) beats, packed back to back from layer 1 upward.
package alpha_mem_pkg;

    localparam int Q_DEF     = 6;
    localparam int P_DEF     = 16;
    localparam int N_DEF     = 1024;
    localparam int LOG_N_DEF = 10;

    function automatic int layer_words(input int l, input int p);
        return ((1 << l) < p) ? 1 : ((1 << l) / p);
    endfunction

    function automatic int layer_base(input int l, input int p);
        int s;
        s = 0;
        for (int i = 1; i < l; i++) s += layer_words(i, p);
        return s;
    endfunction

    function automatic int mem_depth(input int log_n, input int p);
        return layer_base(log_n + 1, p);
    endfunction

    localparam int MEM_DEPTH = mem_depth(LOG_N_DEF, P_DEF);
    localparam int LW        = $clog2(LOG_N_DEF + 1);
    localparam int AW        = $clog2(N_DEF / P_DEF);

    typedef logic [P_DEF*Q_DEF-1:0] beat_t;

endpackage

// File: rtl/alpha_llr_mem_if.sv
// Write/read/status bundle of the alpha LLR store; master drives requests.
interface alpha_llr_mem_if
    import alpha_mem_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int P     = P_DEF,
    parameter int N     = N_DEF,
    parameter int LOG_N = LOG_N_DEF
);
    localparam int LYW = $clog2(LOG_N + 1);
    localparam int ADW = $clog2(N / P);

    logic             clr;
    logic             w_en;
    logic [LYW-1:0]   w_layer;
    logic [ADW-1:0]   w_addr;
    logic [P*Q-1:0]   w_data;
    logic             r_en;
    logic [LYW-1:0]   r_layer;
    logic [ADW-1:0]   r_addr;
    logic [P*Q-1:0]   a_out_left;
    logic [P*Q-1:0]   a_out_right;
    logic             r_valid;
    logic [LOG_N-1:0] layer_done;
    logic             err;

    modport master (
        output clr, w_en, w_layer, w_addr, w_data, r_en, r_layer, r_addr,
        input  a_out_left, a_out_right, r_valid, layer_done, err
    );

    modport slave (
        input  clr, w_en, w_layer, w_addr, w_data, r_en, r_layer, r_addr,
        output a_out_left, a_out_right, r_valid, layer_done, err
    );

endinterface

// File: rtl/alpha_llr_mem_half_split.sv
// Repacks a single stored beat whose layer is narrower than 2P lanes:
// lanes [0,h) go left, lanes [h,2h) shift down to the right output, rest zero.
module alpha_half_split #(
    parameter int Q = 6,
    parameter int P = 16
) (
    input  logic [P*Q-1:0]     word,
    input  logic [$clog2(P):0] h,
    output logic [P*Q-1:0]     left,
    output logic [P*Q-1:0]     right
);
    localparam int HW = $clog2(P) + 1;

    // h is always a power of two, so enumerate it to keep every lane index constant
    always_comb begin
        left  = '0;
        right = '0;
        for (int j = 0; j < HW - 1; j++) begin
            if (h == HW'(1 << j)) begin
                for (int k = 0; k < (1 << j); k++) begin
                    left[k*Q +: Q]  = word[k*Q +: Q];
                    right[k*Q +: Q] = word[(k + (1 << j))*Q +: Q];
                end
            end
        end
    end

endmodule

// File: rtl/alpha_llr_mem.sv
// Alpha LLR store for the SCAN decoder: per-layer beats in one word array,
// half-vector reads with write-first forwarding, layer-done bitmap and sticky err.
module alpha_llr_mem
    import alpha_mem_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int P     = P_DEF,
    parameter int N     = N_DEF,
    parameter int LOG_N = LOG_N_DEF
) (
    input logic            clk,
    input logic            rst,
    alpha_llr_mem_if.slave bus
);
    localparam int LYW   = $clog2(LOG_N + 1);
    localparam int ADW   = $clog2(N / P);
    localparam int DEPTH = mem_depth(LOG_N, P);
    localparam int DW    = $clog2(DEPTH);
    localparam int HW    = $clog2(P) + 1;
    localparam int W     = P * Q;

    logic [W-1:0]   mem [DEPTH];
    logic [ADW:0]   words_tab [LOG_N+1];
    logic [DW-1:0]  base_tab  [LOG_N+1];

    for (genvar l = 0; l <= LOG_N; l++) begin : g_tab
        assign words_tab[l] = (ADW+1)'(layer_words(l, P));
        assign base_tab[l]  = DW'(layer_base(l, P));
    end

    // write side
    logic             w_lyr_ok, w_ok, w_last;
    logic [LYW-1:0]   w_lyr;
    logic [DW-1:0]    w_word;
    logic [LOG_N-1:0] done_set, done_nxt;

    assign w_lyr_ok = (bus.w_layer >= LYW'(1)) && (bus.w_layer <= LYW'(LOG_N));
    assign w_lyr    = w_lyr_ok ? bus.w_layer : LYW'(1);
    assign w_ok     = bus.w_en && w_lyr_ok && ({1'b0, bus.w_addr} < words_tab[w_lyr]);
    assign w_word   = base_tab[w_lyr] + DW'(bus.w_addr);
    assign w_last   = w_ok && ({1'b0, bus.w_addr} == words_tab[w_lyr] - (ADW+1)'(1));
    assign done_set = w_last ? (LOG_N'(1) << (w_lyr - LYW'(1))) : '0;
    // a last-beat write in the clr cycle survives the clear
    assign done_nxt = (bus.clr ? '0 : bus.layer_done) | done_set;

    // read side
    logic           r_lyr_ok, r_split, r_addr_ok, r_ok;
    logic [LYW-1:0] r_lyr;
    logic [ADW:0]   half;
    logic [DW-1:0]  l_word, r_word;
    logic [HW-1:0]  h;
    logic [W-1:0]   l_raw, r_raw, sl_left, sl_right, nx_left, nx_right;

    assign r_lyr_ok  = (bus.r_layer >= LYW'(2)) && (bus.r_layer <= LYW'(LOG_N));
    assign r_lyr     = r_lyr_ok ? bus.r_layer : LYW'(2);
    assign half      = words_tab[r_lyr] >> 1;
    assign r_split   = (half == '0);
    assign l_word    = base_tab[r_lyr] + DW'(bus.r_addr);
    assign r_word    = l_word + DW'(half);
    assign r_addr_ok = r_split ? (bus.r_addr == '0) : ({1'b0, bus.r_addr} < half);
    assign r_ok      = r_lyr_ok && r_addr_ok && done_nxt[r_lyr - LYW'(1)];
    assign h         = HW'(1) << (r_lyr - LYW'(1));

    assign l_raw = (w_ok && (w_word == l_word)) ? bus.w_data : mem[l_word];
    assign r_raw = (w_ok && (w_word == r_word)) ? bus.w_data : mem[r_word];

    alpha_half_split #(.Q(Q), .P(P)) u_split (
        .word  (l_raw),
        .h     (h),
        .left  (sl_left),
        .right (sl_right)
    );

    assign nx_left  = r_split ? sl_left  : l_raw;
    assign nx_right = r_split ? sl_right : r_raw;

    always_ff @(posedge clk) begin
        if (w_ok) mem[w_word] <= bus.w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a_out_left  <= '0;
            bus.a_out_right <= '0;
            bus.r_valid     <= 1'b0;
            bus.layer_done  <= '0;
            bus.err         <= 1'b0;
        end else begin
            bus.r_valid     <= bus.r_en;
            bus.a_out_left  <= (bus.r_en && r_ok) ? nx_left  : '0;
            bus.a_out_right <= (bus.r_en && r_ok) ? nx_right : '0;
            bus.layer_done  <= done_nxt;
            if ((bus.w_en && !w_ok) || (bus.r_en && !r_ok)) bus.err <= 1'b1;
        end
    end

endmodule
